fib_stream: RTL and testbench
=============================

// Module: fib_stream
// PURPOSE
//  Streaming, parametrised successor to the single-result Fibonacci engine. Accepts a request
//  (term count + sequence mode) over a valid/ready channel and emits every term t(0)..t(n-1)
//  on a valid/ready output stream with index, last-flag and sticky overflow flag.
//  Supports Fibonacci, Lucas and user-seeded recurrences, output backpressure and abort.
//  Sits between a command register block and downstream consumers (FIFO, UART formatter).
// PARAMETERS
//  N_IN   7   width of requested term count n (max 2**N_IN-1 terms)
//  N_OUT  90  width of each emitted term
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rst        in   1      asynchronous, active-high reset
//  req_valid  in   1      request valid
//  req_ready  out  1      request ready (high only in IDLE)
//  req_n      in   N_IN   number of terms to emit
//  req_mode   in   2      0=Fibonacci(0,1) 1=Lucas(2,1) 2=custom seeds 3=reserved(treated as 0)
//  seed0      in   N_OUT  t(0) for mode 2, sampled at request accept
//  seed1      in   N_OUT  t(1) for mode 2, sampled at request accept
//  abort      in   1      synchronous cancel of the active request
//  out_valid  out  1      output beat valid
//  out_ready  in   1      output beat accepted when out_valid&&out_ready
//  out_data   out  N_OUT  term value t(idx), modulo 2**N_OUT
//  out_idx    out  N_IN   term index, 0-based
//  out_last   out  1      high on beat idx==n-1
//  out_ovf    out  1      sticky: high if any term t(0..idx) wrapped
//  done       out  1      one-cycle pulse when a request completes (incl. n=0)
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; out_valid=0; out_data=0; out_idx=0; out_last=0;
//   out_ovf=0; done=0; internal term/count registers 0. Reset mid-run drops the request.
//  States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: req_ready=1. On req_valid: latch n, seeds per mode; n==0 -> DONE; else -> RUN.
//   RUN : out_valid=1. Beat k presents t(k); out_* held stable while out_valid&&!out_ready.
//         On handshake: if idx==n-1 -> DONE (out_valid low next cycle); else idx+1, shift
//         recurrence: t(k+1)=t(k)+t(k-1) mod 2**N_OUT, carry-out sets ovf (sticky).
//   DONE: done=1 for exactly one cycle, out_valid=0, -> IDLE (req_ready high next cycle).
//  Latency: request accepted in cycle C -> first beat valid in C+1; with out_ready held
//   high, one beat per cycle; done in cycle after last handshake. Throughput 1 term/cycle.
//  n==1: single beat t(0) with out_last=1. n==2: t(0), t(1); adder not used before idx 2.
//  Overflow: ovf cleared at request accept; out_ovf on beat k reflects wraps in t(0..k).
//  abort: in RUN or DONE -> IDLE next cycle, out_valid=0, no done pulse; ignored in IDLE.
//   abort has priority over a simultaneous output handshake (that beat is still accepted
//   by the consumer; no further beats).
//  req_valid outside IDLE ignored (req_ready=0); requests never queued.
//  No X assignment on any output; illegal state encoding -> IDLE.
// STRUCTURE
//  fib_pkg: mode constants (MODE_FIB, MODE_LUCAS, MODE_SEED), state enum localparams,
//   Lucas seed constants.
//  Sub-module fib_term_gen: two N_OUT term registers + adder with carry-out; ports
//   load/seed0/seed1/advance, outputs cur_term, wrap. FSM, counters, handshake in top.
// TESTING
//  Fib n=10, out_ready=1 -> 0,1,1,2,3,5,8,13,21,34; last on idx 9; done 1 cycle later.
//  Lucas n=5 -> 2,1,3,4,7; custom seeds (5,7) n=4 -> 5,7,12,19; out_ovf=0 throughout.
//  N_OUT=8 fib n=16 -> idx13=233, idx14=121 with out_ovf=1, idx15=98 out_ovf=1 (sticky).
//  Random out_ready backpressure, fib n=20 -> same sequence, data stable during stalls.
//  n=0 -> no beats, done pulse cycle C+1; n=1 -> single beat 0 with out_last=1.
//  abort at idx 4 and rst at idx 6 of n=20 -> IDLE, no done, next request restarts at idx 0.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared constants and types for the streaming Fibonacci/Lucas term generator.
package fib_pkg;

    localparam logic [1:0] MODE_FIB   = 2'd0;
    localparam logic [1:0] MODE_LUCAS = 2'd1;
    localparam logic [1:0] MODE_SEED  = 2'd2;

    localparam int LUCAS_T0 = 2;
    localparam int LUCAS_T1 = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fib_stream_if.sv
// Request and output-stream channel of fib_stream; slave is the generator, master the client.
interface fib_stream_if #(
    parameter int N_IN  = 7,
    parameter int N_OUT = 90
) ();
    logic             req_valid;
    logic             req_ready;
    logic [N_IN-1:0]  req_n;
    logic [1:0]       req_mode;
    logic [N_OUT-1:0] seed0;
    logic [N_OUT-1:0] seed1;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] out_data;
    logic [N_IN-1:0]  out_idx;
    logic             out_last;
    logic             out_ovf;
    logic             done;

    modport slave (
        input  req_valid, req_n, req_mode, seed0, seed1, abort, out_ready,
        output req_ready, out_valid, out_data, out_idx, out_last, out_ovf, done
    );

    modport master (
        output req_valid, req_n, req_mode, seed0, seed1, abort, out_ready,
        input  req_ready, out_valid, out_data, out_idx, out_last, out_ovf, done
    );
endinterface

// File: rtl/fib_term_gen.sv
// Two-term recurrence engine: holds t(k) and t(k+1); the wrap flag belongs to t(k+1),
// so it is folded into the sticky overflow only when that term becomes current.
module fib_term_gen #(
    parameter int N_OUT = 90
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [N_OUT-1:0] seed0,
    input  logic [N_OUT-1:0] seed1,
    input  logic             advance,
    output logic [N_OUT-1:0] cur_term,
    output logic             wrap
);
    logic [N_OUT-1:0] cur_q;
    logic [N_OUT-1:0] nxt_q;
    logic             nxt_wrap_q;
    logic [N_OUT:0]   sum;

    assign sum = {1'b0, cur_q} + {1'b0, nxt_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q      <= '0;
            nxt_q      <= '0;
            nxt_wrap_q <= 1'b0;
        end else if (load) begin
            cur_q      <= seed0;
            nxt_q      <= seed1;
            nxt_wrap_q <= 1'b0;
        end else if (advance) begin
            cur_q      <= nxt_q;
            nxt_q      <= sum[N_OUT-1:0];
            nxt_wrap_q <= sum[N_OUT];
        end
    end

    assign cur_term = cur_q;
    assign wrap     = nxt_wrap_q;
endmodule

// File: rtl/fib_stream.sv
// Streams t(0)..t(n-1) of a Fibonacci, Lucas or seeded recurrence over a valid/ready
// channel, with index, last flag, sticky overflow, done pulse and abort.
module fib_stream
    import fib_pkg::*;
#(
    parameter int N_IN  = 7,
    parameter int N_OUT = 90
) (
    input  logic         clk,
    input  logic         rst,
    fib_stream_if.slave  bus
);
    state_e           state_q;
    logic [N_IN-1:0]  n_q;
    logic [N_IN-1:0]  idx_q;
    logic             last_q;
    logic             ovf_q;
    logic             valid_q;
    logic             ready_q;
    logic             done_q;

    logic [N_OUT-1:0] seed0_sel;
    logic [N_OUT-1:0] seed1_sel;
    logic [N_OUT-1:0] cur_term;
    logic             term_wrap;
    logic             accept;
    logic             fire;
    logic             advance;
    logic [N_IN-1:0]  idx_inc;
    logic [N_IN-1:0]  n_m1;

    always_comb begin
        seed0_sel = '0;
        seed1_sel = N_OUT'(1);
        case (bus.req_mode)
            MODE_LUCAS: begin
                seed0_sel = N_OUT'(LUCAS_T0);
                seed1_sel = N_OUT'(LUCAS_T1);
            end
            MODE_SEED: begin
                seed0_sel = bus.seed0;
                seed1_sel = bus.seed1;
            end
            default: ;
        endcase
    end

    assign accept  = (state_q == ST_IDLE) && bus.req_valid;
    assign fire    = (state_q == ST_RUN) && bus.out_ready;
    // An abort in the same cycle as a handshake ends the stream; the term registers stay put.
    assign advance = fire && !last_q && !bus.abort;
    assign idx_inc = idx_q + N_IN'(1);
    assign n_m1    = n_q - N_IN'(1);

    fib_term_gen #(.N_OUT(N_OUT)) u_term_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .seed0    (seed0_sel),
        .seed1    (seed1_sel),
        .advance  (advance),
        .cur_term (cur_term),
        .wrap     (term_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.req_valid) begin
                        n_q     <= bus.req_n;
                        idx_q   <= '0;
                        last_q  <= (bus.req_n == N_IN'(1));
                        ovf_q   <= 1'b0;
                        ready_q <= 1'b0;
                        if (bus.req_n == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        if (last_q) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q  <= idx_inc;
                            last_q <= (idx_inc == n_m1);
                            ovf_q  <= ovf_q | term_wrap;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = cur_term;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_fib_stream.sv
// Self-checking bench for fib_stream: a transaction-level model of the stream compared
// every cycle, plus directed literal checks, an 8-bit instance for wrap/overflow.
module tb_fib_stream;
    localparam int NI = 7;
    localparam int NO = 90;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fib_stream_if #(.N_IN(NI), .N_OUT(NO)) bus ();
    fib_stream_if #(.N_IN(7),  .N_OUT(8))  bus8 ();

    fib_stream #(.N_IN(NI), .N_OUT(NO)) dut  (.clk(clk), .rst(rst), .bus(bus));
    fib_stream #(.N_IN(7),  .N_OUT(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Unbounded-value recurrence term, computed from scratch for index k.
    function automatic logic [127:0] true_term(input logic [1:0] mode, input logic [127:0] s0,
                                               input logic [127:0] s1, input int k);
        logic [127:0] a, b, c;
        case (mode)
            2'd1:    begin a = 128'd2; b = 128'd1; end
            2'd2:    begin a = s0;     b = s1;     end
            default: begin a = 128'd0; b = 128'd1; end
        endcase
        for (int i = 0; i < k; i++) begin
            c = a + b;
            a = b;
            b = c;
        end
        return a;
    endfunction

    typedef struct {
        logic [NO-1:0] data;
        int            idx;
        logic          last;
        logic          ovf;
    } beat_t;

    typedef enum {P_IDLE, P_RUN, P_DONE} phase_t;

    beat_t         exp_q[$];
    phase_t        ph = P_IDLE;
    logic [NO-1:0] got_data [0:255];
    logic          got_last [0:255];
    logic          got_ovf  [0:255];
    int            got_cnt = 0;
    beat_t         m_b;
    logic [127:0]  m_tv;
    logic          m_ov;
    int            m_n;
    logic          m_popped_last;

    // Transaction model and per-cycle compare on the 90-bit instance.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", 128'(bus.req_ready), 128'd1);
            chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
            chk("rst_out_data",  128'(bus.out_data),  128'd0);
            chk("rst_out_idx",   128'(bus.out_idx),   128'd0);
            chk("rst_out_last",  128'(bus.out_last),  128'd0);
            chk("rst_out_ovf",   128'(bus.out_ovf),   128'd0);
            chk("rst_done",      128'(bus.done),      128'd0);
            ph = P_IDLE;
            exp_q.delete();
        end else begin
            chk("req_ready", 128'(bus.req_ready), 128'(ph == P_IDLE));
            chk("out_valid", 128'(bus.out_valid), 128'(ph == P_RUN));
            chk("done",      128'(bus.done),      128'(ph == P_DONE));
            case (ph)
                P_IDLE: begin
                    if (bus.req_valid) begin
                        m_n  = int'(bus.req_n);
                        m_ov = 1'b0;
                        for (int k = 0; k < m_n; k++) begin
                            m_tv = true_term(bus.req_mode, 128'(bus.seed0), 128'(bus.seed1), k);
                            m_ov = m_ov | ((m_tv >> NO) != 128'd0);
                            m_b.data = m_tv[NO-1:0];
                            m_b.idx  = k;
                            m_b.last = (k == m_n - 1);
                            m_b.ovf  = m_ov;
                            exp_q.push_back(m_b);
                        end
                        ph = (m_n == 0) ? P_DONE : P_RUN;
                    end
                end
                P_RUN: begin
                    m_popped_last = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("model_beats_left", 128'd0, 128'd1);
                    end else begin
                        m_b = exp_q[0];
                        chk("out_data", 128'(bus.out_data), 128'(m_b.data));
                        chk("out_idx",  128'(bus.out_idx),  128'(m_b.idx));
                        chk("out_last", 128'(bus.out_last), 128'(m_b.last));
                        chk("out_ovf",  128'(bus.out_ovf),  128'(m_b.ovf));
                        if (bus.out_ready) begin
                            got_data[got_cnt[7:0]] = bus.out_data;
                            got_last[got_cnt[7:0]] = bus.out_last;
                            got_ovf[got_cnt[7:0]]  = bus.out_ovf;
                            got_cnt++;
                            m_popped_last = m_b.last;
                            void'(exp_q.pop_front());
                        end
                    end
                    if (bus.abort) begin
                        exp_q.delete();
                        ph = P_IDLE;
                    end else if (m_popped_last) begin
                        ph = P_DONE;
                    end
                end
                default: ph = P_IDLE;
            endcase
        end
    end

    // out_ready driver: 0 = low, 1 = high, 2 = random backpressure.
    int ready_mode = 1;
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send(input int n, input logic [1:0] mode, input int s0, input int s1);
        bit ok;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_n     = NI'(n);
        bus.req_mode  = mode;
        bus.seed0     = NO'(s0);
        bus.seed1     = NO'(s1);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
        end
        chk("req_accept_timeout", 128'(ok), 128'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.seed0     = '0;
        bus.seed1     = '0;
    endtask

    task automatic wait_done(input int bound);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < bound && !ok; c++) begin
            @(negedge clk);
            if (bus.done) ok = 1'b1;
        end
        chk("done_timeout", 128'(ok), 128'd1);
    endtask

    task automatic wait_idx(input int k);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready && int'(bus.out_idx) == k) ok = 1'b1;
        end
        chk("idx_timeout", 128'(ok), 128'd1);
    endtask

    task automatic no_done_for(input int cycles);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("no_done_after_cancel", 128'(seen), 128'd0);
    endtask

    int fib10 [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    int luc5  [5]  = '{2, 1, 3, 4, 7};
    int cus4  [4]  = '{5, 7, 12, 19};
    int base;
    logic [7:0] d8   [0:15];
    logic       o8   [0:15];
    int         cnt8;
    bit         done8;
    logic [127:0] tv8;
    logic         ov8;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_n      = '0;
        bus.req_mode   = 2'd0;
        bus.seed0      = '0;
        bus.seed1      = '0;
        bus.abort      = 1'b0;
        bus8.req_valid = 1'b0;
        bus8.req_n     = '0;
        bus8.req_mode  = 2'd0;
        bus8.seed0     = '0;
        bus8.seed1     = '0;
        bus8.abort     = 1'b0;
        bus8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fibonacci, n=10
        base = got_cnt;
        send(10, 2'd0, 0, 0);
        wait_done(60);
        chk("fib10_count", 128'(got_cnt - base), 128'd10);
        for (int i = 0; i < 10; i++) begin
            $display("fib10 beat %0d = %0d", i, got_data[base + i]);
            chk("fib10_data", 128'(got_data[base + i]), 128'(fib10[i]));
        end
        chk("fib10_last9", 128'(got_last[base + 9]), 128'd1);
        chk("fib10_last8", 128'(got_last[base + 8]), 128'd0);

        // Lucas, n=5
        base = got_cnt;
        send(5, 2'd1, 0, 0);
        wait_done(40);
        for (int i = 0; i < 5; i++)
            chk("lucas5_data", 128'(got_data[base + i]), 128'(luc5[i]));

        // Custom seeds (5,7), n=4
        base = got_cnt;
        send(4, 2'd2, 5, 7);
        wait_done(40);
        for (int i = 0; i < 4; i++) begin
            chk("seed4_data", 128'(got_data[base + i]), 128'(cus4[i]));
            chk("seed4_ovf",  128'(got_ovf[base + i]),  128'd0);
        end

        // Reserved mode behaves as Fibonacci
        base = got_cnt;
        send(4, 2'd3, 9, 9);
        wait_done(40);
        chk("mode3_idx3", 128'(got_data[base + 3]), 128'd2);

        // Random backpressure, fib n=20
        base = got_cnt;
        ready_mode = 2;
        send(20, 2'd0, 0, 0);
        wait_done(600);
        ready_mode = 1;
        chk("bp_count", 128'(got_cnt - base), 128'd20);
        chk("bp_idx19", 128'(got_data[base + 19]), 128'd4181);

        // n=0 and n=1
        base = got_cnt;
        send(0, 2'd0, 0, 0);
        wait_done(3);
        chk("n0_beats", 128'(got_cnt - base), 128'd0);
        send(1, 2'd0, 0, 0);
        wait_done(10);
        chk("n1_beats", 128'(got_cnt - base), 128'd1);
        chk("n1_data",  128'(got_data[base]), 128'd0);
        chk("n1_last",  128'(got_last[base]), 128'd1);

        // Abort during idx 4 of n=20
        base = got_cnt;
        send(20, 2'd0, 0, 0);
        wait_idx(3);
        @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        no_done_for(5);
        chk("abort_beats", 128'(got_cnt - base), 128'd5);
        base = got_cnt;
        send(3, 2'd0, 0, 0);
        wait_done(20);
        chk("post_abort_t1", 128'(got_data[base + 1]), 128'd1);

        // Reset during idx 6 of n=20
        base = got_cnt;
        send(20, 2'd0, 0, 0);
        wait_idx(5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        no_done_for(4);
        chk("rst_beats", 128'(got_cnt - base), 128'd6);
        base = got_cnt;
        send(2, 2'd0, 0, 0);
        wait_done(20);
        chk("post_rst_t0", 128'(got_data[base]),     128'd0);
        chk("post_rst_t1", 128'(got_data[base + 1]), 128'd1);

        // 8-bit instance: fib n=16 wraps at idx 14
        @(posedge clk);
        #1;
        bus8.req_valid = 1'b1;
        bus8.req_n     = 7'd16;
        @(posedge clk);
        #1;
        bus8.req_valid = 1'b0;
        cnt8  = 0;
        done8 = 1'b0;
        for (int c = 0; c < 100 && !done8; c++) begin
            @(negedge clk);
            if (bus8.out_valid && cnt8 < 16) begin
                d8[cnt8] = bus8.out_data;
                o8[cnt8] = bus8.out_ovf;
                cnt8++;
            end
            if (bus8.done) done8 = 1'b1;
        end
        chk("w8_done",  128'(done8), 128'd1);
        chk("w8_count", 128'(cnt8),  128'd16);
        ov8 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tv8 = true_term(2'd0, 128'd0, 128'd0, k);
            ov8 = ov8 | (tv8 >= 128'd256);
            chk("w8_data", 128'(d8[k]), 128'(tv8[7:0]));
            chk("w8_ovf",  128'(o8[k]), 128'(ov8));
        end
        chk("w8_idx13", 128'(d8[13]), 128'd233);
        chk("w8_ovf13", 128'(o8[13]), 128'd0);
        chk("w8_idx14", 128'(d8[14]), 128'd121);
        chk("w8_ovf14", 128'(o8[14]), 128'd1);
        chk("w8_idx15", 128'(d8[15]), 128'd98);
        chk("w8_ovf15", 128'(o8[15]), 128'd1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
